// File: rtl/throttle_pwm.sv
// Servo-style throttle PWM: microsecond timebase, frame-synchronous slew-limited
// command, and a three-state pulse generator that truncates the pulse when disarmed.
module throttle_pwm #(
    parameter int CLOCKS_PER_US = 65,
    parameter int FRAME_US      = 20000,
    parameter int MIN_US        = 1000,
    parameter int MAX_US        = 2000,
    parameter int SLEW          = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       on,
    input  logic [7:0] hover,
    output logic       pwm_out,
    output logic       frame_strobe,
    output logic [7:0] applied
);

    // state    | meaning
    // DISARMED | no pulse this frame; waiting for a boundary with on=1
    // PULSE    | pwm_out high, us_cnt below the latched width
    // GAP      | pulse finished (or cut short); low until the next boundary

    localparam int PW = (CLOCKS_PER_US > 1) ? $clog2(CLOCKS_PER_US) : 1;
    localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int CW = (UW > 12) ? UW : 12;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLOCKS_PER_US - 1);
    localparam logic [UW-1:0] US_LAST  = UW'(FRAME_US - 1);
    localparam logic [8:0]    SLEW9    = 9'(SLEW);
    localparam logic [CW-1:0] MIN_W    = CW'(MIN_US);
    localparam logic [CW-1:0] MAX_W    = CW'(MAX_US);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc;
    logic [UW-1:0]   us_cnt;
    logic [CW-1:0]   width, width_nxt, raw_w;
    logic [7:0]      applied_nxt;
    logic [8:0]      a9, h9, up9, dn9;
    logic            tick, boundary, pulse_end;

    assign tick      = (presc == PRE_LAST);
    assign boundary  = tick && (us_cnt == US_LAST);
    assign pulse_end = tick && (CW'(us_cnt) == (width - CW'(1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (tick) begin
            presc  <= '0;
            us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + UW'(1);
        end else begin
            presc  <= presc + PW'(1);
        end
    end

    // Slew step done at 9 bits so neither the +SLEW nor the -SLEW path can wrap.
    assign a9  = {1'b0, applied};
    assign h9  = {1'b0, hover};
    assign up9 = a9 + SLEW9;
    assign dn9 = a9 - SLEW9;

    always_comb begin
        applied_nxt = applied;
        if (!on) begin
            applied_nxt = 8'd0;
        end else if (h9 > up9) begin
            applied_nxt = up9[7:0];
        end else if ((a9 >= SLEW9) && (h9 < dn9)) begin
            applied_nxt = dn9[7:0];
        end else begin
            applied_nxt = hover;
        end
        raw_w     = MIN_W + (CW'(applied_nxt) << 2);
        width_nxt = (raw_w > MAX_W) ? MAX_W : raw_w;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            applied <= '0;
            width   <= '0;
        end else if (boundary) begin
            applied <= applied_nxt;
            width   <= width_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DISARMED: begin
                if (boundary && on) state_nxt = PULSE;
            end
            PULSE: begin
                if (boundary)               state_nxt = on ? PULSE : DISARMED;
                else if (!on || pulse_end)  state_nxt = GAP;
            end
            GAP: begin
                if (boundary)               state_nxt = on ? PULSE : DISARMED;
            end
            default: state_nxt = DISARMED;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= DISARMED;
            pwm_out      <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            state        <= state_nxt;
            pwm_out      <= (state_nxt == PULSE);
            frame_strobe <= boundary;
        end
    end

endmodule
